// File: rtl/ce_serializer_if.sv
// Word handshake between a producer and ce_serializer.
// The producer drives the word and its valid flag; the serializer answers with ready.
interface ce_serializer_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] DATA_IN;
  logic             DATA_VALID;
  logic             DATA_READY;

  modport master (
    output DATA_IN,
    output DATA_VALID,
    input  DATA_READY
  );

  modport slave (
    input  DATA_IN,
    input  DATA_VALID,
    output DATA_READY
  );
endinterface

// File: rtl/ce_serializer.sv
// Parallel-to-serial shifter paced by a one-CLK clock-enable pulse from the clock divider.
// One word per valid/ready handshake, one bit on SDO per CE period, framed by SFRAME.
module ce_serializer #(
  parameter int WIDTH      = 32,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CE,
  ce_serializer_if.slave     dif,
  output logic               SDO,
  output logic               SFRAME,
  output logic               BIT_STROBE,
  output logic               DONE,
  output logic               BUSY
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shift_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  logic             sdo_r;
  logic             sdo_nx_s;
  logic             sframe_r;
  logic             sframe_nx_s;
  logic             strobe_r;
  logic             strobe_nx_s;
  logic             done_r;
  logic             done_nx_s;
  logic             accept_s;

  // The bit that leaves the shift register next, depending on shift order.
  function automatic logic head_bit(input logic [WIDTH-1:0] word);
    if (MSB_FIRST) begin
      return word[WIDTH-1];
    end else begin
      return word[0];
    end
  endfunction

  // Drop the bit just sent so the following one moves into the head position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] word);
    if (MSB_FIRST) begin
      return {word[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, word[WIDTH-1:1]};
    end
  endfunction

  assign accept_s       = dif.DATA_VALID & dif.DATA_READY;
  assign dif.DATA_READY = (state_r == ST_IDLE);
  assign BUSY           = (state_r == ST_ARMED) || (state_r == ST_SHIFT);
  assign SDO            = sdo_r;
  assign SFRAME         = sframe_r;
  assign BIT_STROBE     = strobe_r;
  assign DONE           = done_r;

  // State and datapath registers; reset drops any word in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r  <= ST_IDLE;
      shift_r  <= {WIDTH{1'b0}};
      cnt_r    <= CNT_ZERO;
      sdo_r    <= IDLE_LEVEL;
      sframe_r <= 1'b0;
      strobe_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      shift_r  <= shift_nx_s;
      cnt_r    <= cnt_nx_s;
      sdo_r    <= sdo_nx_s;
      sframe_r <= sframe_nx_s;
      strobe_r <= strobe_nx_s;
      done_r   <= done_nx_s;
    end
  end

  // Next-state logic: CE is only looked at once a word has been armed.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx_s = ST_ARMED;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (CE) begin
          state_nx_s = ST_SHIFT;
        end else begin
          state_nx_s = ST_ARMED;
        end
      end
      ST_SHIFT: begin
        if (CE && (cnt_r == CNT_ZERO)) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Output and datapath next values; strobe and done are single-cycle pulses.
  always_comb begin
    shift_nx_s  = shift_r;
    cnt_nx_s    = cnt_r;
    sdo_nx_s    = sdo_r;
    sframe_nx_s = sframe_r;
    strobe_nx_s = 1'b0;
    done_nx_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          shift_nx_s = dif.DATA_IN;
        end else begin
          shift_nx_s = shift_r;
        end
      end
      ST_ARMED: begin
        if (CE) begin
          sdo_nx_s    = head_bit(shift_r);
          shift_nx_s  = advance(shift_r);
          sframe_nx_s = 1'b1;
          strobe_nx_s = 1'b1;
          cnt_nx_s    = CNT_LAST;
        end else begin
          sframe_nx_s = sframe_r;
        end
      end
      ST_SHIFT: begin
        if (CE) begin
          // The counter reaching zero means the last bit has had its full period.
          if (cnt_r != CNT_ZERO) begin
            sdo_nx_s    = head_bit(shift_r);
            shift_nx_s  = advance(shift_r);
            strobe_nx_s = 1'b1;
            cnt_nx_s    = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            sdo_nx_s    = IDLE_LEVEL;
            sframe_nx_s = 1'b0;
            done_nx_s   = 1'b1;
          end
        end else begin
          sdo_nx_s = sdo_r;
        end
      end
      default: begin
        shift_nx_s  = {WIDTH{1'b0}};
        cnt_nx_s    = CNT_ZERO;
        sdo_nx_s    = IDLE_LEVEL;
        sframe_nx_s = 1'b0;
      end
    endcase
  end

endmodule
